// File: rtl/i2c_init_sequencer.sv
// Purpose : walks an external init-table ROM and issues one single-byte I2C write per entry.
// Latency : start -> ctrl_enable 2 cycles; ready fall -> enable fall 1 cycle; GAP_CYCLES idle after each stop.
// Backpr. : waits on the controller ready handshake per phase; a stalled phase ends in ERROR after TIMEOUT cycles.
// Ports   : clk/reset (sync, active high); start pulse; table_addr/table_data ROM port;
//           ctrl_ready/ctrl_enable/ctrl_mode/ctrl_addr/ctrl_byte controller port;
//           busy/done/error/err_index status to the synth top level.
module i2c_init_sequencer #(
   parameter int unsigned NUM_ENTRIES = 16,
   parameter logic [6:0]  PERIPH_ADDR = 7'h1A,
   parameter int unsigned GAP_CYCLES  = 64,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] table_addr,
   input  logic [7:0] table_data,
   input  logic       ctrl_ready,
   output logic       ctrl_enable,
   output logic       ctrl_mode,
   output logic [6:0] ctrl_addr,
   output logic [7:0] ctrl_byte,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [7:0] err_index
);

   // Timer only ever has to hold TIMEOUT-1, gap counter GAP_CYCLES-1.
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
   localparam logic [7:0]    LAST = 8'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT_DONE,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    table_addr_q, table_addr_d;
   logic          ctrl_enable_q, ctrl_enable_d;
   logic [7:0]    ctrl_byte_q, ctrl_byte_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [7:0]    err_index_q, err_index_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [GW-1:0] gap_q, gap_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         table_addr_q  <= 8'h00;
         ctrl_enable_q <= 1'b0;
         ctrl_byte_q   <= 8'h00;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_index_q   <= 8'h00;
         timer_q       <= '0;
         gap_q         <= '0;
      end else begin
         state_q       <= state_d;
         table_addr_q  <= table_addr_d;
         ctrl_enable_q <= ctrl_enable_d;
         ctrl_byte_q   <= ctrl_byte_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         err_index_q   <= err_index_d;
         timer_q       <= timer_d;
         gap_q         <= gap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      table_addr_d  = table_addr_q;
      ctrl_enable_d = ctrl_enable_q;
      ctrl_byte_d   = ctrl_byte_q;
      busy_d        = busy_q;
      done_d        = done_q;
      error_d       = error_q;
      err_index_d   = err_index_q;
      timer_d       = timer_q;
      gap_d         = gap_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d      = S_FETCH;
               table_addr_d = 8'h00;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               error_d      = 1'b0;
            end
         end
         S_FETCH: begin
            ctrl_byte_d   = table_data;
            ctrl_enable_d = 1'b1;
            timer_d       = '0;
            state_d       = S_ISSUE;
         end
         S_ISSUE: begin
            // Acceptance is checked before expiry so a tie goes to the handshake.
            // Enable must drop right away: the controller re-arms while it stays high.
            if (!ctrl_ready) begin
               ctrl_enable_d = 1'b0;
               timer_d       = '0;
               state_d       = S_WAIT_DONE;
            end else if (timer_q == TMAX) begin
               ctrl_enable_d = 1'b0;
               err_index_d   = table_addr_q;
               error_d       = 1'b1;
               busy_d        = 1'b0;
               state_d       = S_ERROR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (ctrl_ready) begin
               gap_d   = '0;
               state_d = S_GAP;
            end else if (timer_q == TMAX) begin
               ctrl_enable_d = 1'b0;
               err_index_d   = table_addr_q;
               error_d       = 1'b1;
               busy_d        = 1'b0;
               state_d       = S_ERROR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GMAX) begin
               if (table_addr_q == LAST) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  table_addr_d = table_addr_q + 8'd1;
                  state_d      = S_FETCH;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign table_addr  = table_addr_q;
   assign ctrl_enable = ctrl_enable_q;
   assign ctrl_mode   = 1'b1;
   assign ctrl_addr   = PERIPH_ADDR;
   assign ctrl_byte   = ctrl_byte_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_index   = err_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Purpose : self-checking bench for i2c_init_sequencer with a scripted I2C controller model.
// Latency : expected event cycles come from a closed-form timing model of each transaction.
// Backpr. : the controller model delays acceptance and completion per entry to exercise timeouts.
module tb_i2c_init_sequencer;

   localparam int N = 3;
   localparam int G = 4;
   localparam int T = 24;
   localparam logic [6:0] PA = 7'h1A;

   logic       clk = 1'b0;
   logic       reset, start, ctrl_ready;
   logic [7:0] table_addr, table_data, ctrl_byte, err_index;
   logic       ctrl_enable, ctrl_mode, busy, done, error;
   logic [6:0] ctrl_addr;

   logic [7:0] rom [N];
   int checks = 0;
   int errors = 0;

   // Per-entry controller behaviour: accept delay (cycles enable is seen high
   // before ready drops) and how many cycles ready then stays low.
   int plan_d [N];
   int plan_l [N];
   int exp_err_index = 0;

   // Reference predictions.
   int m_rise [N];
   int m_w    [N];
   int m_np, m_out, m_idx;
   bit m_err;

   typedef struct packed {
      logic [7:0] d0, d1, d2;
      logic [7:0] l0, l1, l2;
      logic [7:0] spur;
      logic       exp_err;
      logic [7:0] exp_idx;
   } vec_t;

   i2c_init_sequencer #(
      .NUM_ENTRIES(N), .PERIPH_ADDR(PA), .GAP_CYCLES(G), .TIMEOUT(T)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .table_addr(table_addr), .table_data(table_data),
      .ctrl_ready(ctrl_ready), .ctrl_enable(ctrl_enable), .ctrl_mode(ctrl_mode),
      .ctrl_addr(ctrl_addr), .ctrl_byte(ctrl_byte),
      .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   assign table_data = (table_addr < 8'(N)) ? rom[table_addr[1:0]] : 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Start is driven just after edge 0, so entry 0 enable rises at edge 2.
   // Each entry occupies d+1 ISSUE cycles, L WAIT_DONE cycles, G gap cycles and one FETCH.
   task automatic predict();
      int r = 2;
      m_np = 0; m_err = 0; m_idx = 0; m_out = 0;
      for (int i = 0; i < N; i++) begin
         m_rise[i] = r;
         m_np++;
         if (plan_d[i] >= T) begin
            m_err = 1; m_idx = i; m_w[i] = T; m_out = r + T;
            break;
         end
         m_w[i] = plan_d[i] + 1;
         if (plan_l[i] > T) begin
            m_err = 1; m_idx = i; m_out = r + plan_d[i] + 1 + T;
            break;
         end
         m_out = r + plan_d[i] + plan_l[i] + 1 + G;
         r = r + plan_d[i] + plan_l[i] + G + 2;
      end
   endtask

   task automatic run_seq(input string tag, input int spur, input int rst_entry);
      int n, k, lc, phase, idx, npulse, out_n, busy_bad, sticky_bad, const_bad, post;
      int rise_n [N];
      int width  [N];
      int byte_seen [N];
      int addr_seen [N];
      bit prev_en, got_out, rst_pending, timed_out, out_done, out_err;
      predict();
      n = 0; k = 0; lc = 0; phase = 0; idx = 0; npulse = 0; out_n = -1;
      busy_bad = 0; sticky_bad = 0; const_bad = 0; post = 0;
      got_out = 0; rst_pending = 0; timed_out = 0; out_done = 0; out_err = 0;
      for (int i = 0; i < N; i++) begin
         rise_n[i] = -1; width[i] = -1; byte_seen[i] = -1; addr_seen[i] = -1;
      end
      ctrl_ready = 1'b1;
      prev_en = ctrl_enable;
      start = 1'b1;
      while (1) begin
         @(posedge clk); #1;
         n++;
         start = (n == spur);
         if (rst_pending) begin
            reset = 1'b0;
            chk({tag, " pulses_before_reset"}, npulse, rst_entry + 1);
            chk({tag, " reset_enable"}, ctrl_enable, 0);
            chk({tag, " reset_table_addr"}, table_addr, 0);
            chk({tag, " reset_busy"}, busy, 0);
            chk({tag, " reset_done_error"}, {done, error}, 0);
            chk({tag, " reset_err_index"}, err_index, 0);
            exp_err_index = 0;
            return;
         end
         if (ctrl_enable && !prev_en) begin
            if (npulse < N) begin
               rise_n[npulse] = n;
               byte_seen[npulse] = ctrl_byte;
               addr_seen[npulse] = table_addr;
            end
            idx = npulse;
            npulse++;
         end
         if (!ctrl_enable && prev_en && idx < N) width[idx] = n - rise_n[idx];
         if (busy !== ((n >= 1) && (n < m_out))) busy_bad++;
         if (ctrl_mode !== 1'b1 || ctrl_addr !== PA) const_bad++;

         // Controller model.
         if (phase == 1) begin
            if (!ctrl_enable) phase = 0;
            else k++;
         end
         if (ctrl_enable && !prev_en) begin
            phase = 1; k = 0;
         end
         if (phase == 1 && idx < N && k == plan_d[idx]) begin
            ctrl_ready = 1'b0; phase = 2; lc = 0;
         end else if (phase == 2) begin
            lc++;
            if (lc >= plan_l[idx]) begin
               ctrl_ready = 1'b1; phase = 0;
            end
         end
         prev_en = ctrl_enable;

         if (rst_entry >= 0 && npulse == rst_entry + 1 && n == rise_n[rst_entry]) begin
            reset = 1'b1;
            ctrl_ready = 1'b1;
            rst_pending = 1;
            continue;
         end

         if (!got_out && (done || error)) begin
            got_out = 1; out_n = n; out_done = done; out_err = error;
         end else if (got_out) begin
            if (done !== out_done || error !== out_err || ctrl_enable !== 1'b0) sticky_bad++;
            post++;
            if (post == 3) break;
         end
         if (n > 600) begin
            timed_out = 1;
            break;
         end
      end
      chk({tag, " cycle_budget_expired"}, timed_out, 0);
      chk({tag, " pulse_count"}, npulse, m_np);
      for (int i = 0; i < m_np; i++) begin
         chk($sformatf("%s pulse%0d rise_cycle", tag, i), rise_n[i], m_rise[i]);
         chk($sformatf("%s pulse%0d width", tag, i), width[i], m_w[i]);
         chk($sformatf("%s pulse%0d byte", tag, i), byte_seen[i], rom[i]);
         chk($sformatf("%s pulse%0d table_addr", tag, i), addr_seen[i], i);
      end
      chk({tag, " outcome_cycle"}, out_n, m_out);
      chk({tag, " done"}, out_done, !m_err);
      chk({tag, " error"}, out_err, m_err);
      if (m_err) exp_err_index = m_idx;
      chk({tag, " err_index"}, err_index, exp_err_index);
      chk({tag, " busy_profile_bad_cycles"}, busy_bad, 0);
      chk({tag, " sticky_status_bad_cycles"}, sticky_bad, 0);
      chk({tag, " const_outputs_bad_cycles"}, const_bad, 0);
   endtask

   initial begin
      vec_t vecs [7];
      vecs[0] = '{d0: 8'd0,  d1: 8'd0, d2: 8'd0,  l0: 8'd20, l1: 8'd20, l2: 8'd20, spur: 8'd0, exp_err: 1'b0, exp_idx: 8'd0};
      vecs[1] = '{d0: 8'd99, d1: 8'd0, d2: 8'd0,  l0: 8'd3,  l1: 8'd3,  l2: 8'd3,  spur: 8'd0, exp_err: 1'b1, exp_idx: 8'd0};
      vecs[2] = '{d0: 8'd0,  d1: 8'd2, d2: 8'd0,  l0: 8'd5,  l1: 8'd99, l2: 8'd3,  spur: 8'd0, exp_err: 1'b1, exp_idx: 8'd1};
      vecs[3] = '{d0: 8'd23, d1: 8'd0, d2: 8'd0,  l0: 8'd3,  l1: 8'd3,  l2: 8'd3,  spur: 8'd0, exp_err: 1'b0, exp_idx: 8'd1};
      vecs[4] = '{d0: 8'd1,  d1: 8'd1, d2: 8'd1,  l0: 8'd1,  l1: 8'd1,  l2: 8'd24, spur: 8'd0, exp_err: 1'b0, exp_idx: 8'd1};
      vecs[5] = '{d0: 8'd0,  d1: 8'd0, d2: 8'd24, l0: 8'd2,  l1: 8'd2,  l2: 8'd2,  spur: 8'd0, exp_err: 1'b1, exp_idx: 8'd2};
      vecs[6] = '{d0: 8'd0,  d1: 8'd0, d2: 8'd0,  l0: 8'd6,  l1: 8'd6,  l2: 8'd6,  spur: 8'd5, exp_err: 1'b0, exp_idx: 8'd2};

      rom[0] = 8'h1E; rom[1] = 8'h00; rom[2] = 8'h0C;
      reset = 1'b1; start = 1'b0; ctrl_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("reset table_addr", table_addr, 0);
      chk("reset ctrl_enable", ctrl_enable, 0);
      chk("reset ctrl_byte", ctrl_byte, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset error", error, 0);
      chk("reset err_index", err_index, 0);
      chk("ctrl_mode", ctrl_mode, 1);
      chk("ctrl_addr", ctrl_addr, PA);

      for (int v = 0; v < 7; v++) begin
         plan_d[0] = vecs[v].d0; plan_d[1] = vecs[v].d1; plan_d[2] = vecs[v].d2;
         plan_l[0] = vecs[v].l0; plan_l[1] = vecs[v].l1; plan_l[2] = vecs[v].l2;
         run_seq($sformatf("vec%0d", v), vecs[v].spur, -1);
         chk($sformatf("vec%0d table_error", v), error, vecs[v].exp_err);
         chk($sformatf("vec%0d table_err_index", v), err_index, vecs[v].exp_idx);
      end

      // Reset while entry 2 sits in ISSUE, then a fresh start must replay every entry.
      rom[0] = 8'hA5; rom[1] = 8'h5A; rom[2] = 8'h3C;
      plan_d[0] = 0; plan_d[1] = 0; plan_d[2] = 99;
      plan_l[0] = 3; plan_l[1] = 3; plan_l[2] = 3;
      run_seq("midreset", 0, 2);
      plan_d[0] = 0; plan_d[1] = 1; plan_d[2] = 2;
      plan_l[0] = 2; plan_l[1] = 3; plan_l[2] = 4;
      run_seq("replay", 0, -1);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) begin
            rom[i] = 8'($urandom_range(0, 255));
            plan_d[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5) : $urandom_range(0, T + 2);
            plan_l[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 6) : $urandom_range(1, T + 3);
         end
         run_seq($sformatf("rand%0d", r), ($urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : 0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
